nec_ir_encoder: RTL and testbench

NEC-protocol infrared transmitter, the send side of the board's NEC IR link. Accepts an 8-bit address and 8-bit command over a start/busy handshake and emits one NEC frame. The frame is a 9 ms leader, 4.5 ms space, 32 data bits LSB first, and a stop mark, followed by an enforced inter-frame gap. Drives the IR LED pin, with a carrier-modulated or plain envelope depending on build.

---
 rtl/nec_ir_encoder.sv | 210 +++++++++++++++++++++
 tb/tb_nec_ir_encoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nec_ir_encoder.sv
`timescale 1ns/1ps
// NEC IR transmitter: one frame (leader, 32 data bits LSB first, stop mark, gap) per accepted request.
// Latency: START sampled at an edge drives IR_ENVELOPE/BUSY high from that edge; all outputs registered.
// Backpressure: START is ignored while BUSY and never queued; START in the DONE cycle is accepted.
//
// Ports:
//   CLOCK_50    in   system clock
//   RESET       in   asynchronous, active-high reset; aborts any frame without a DONE pulse
//   START       in   send request, accepted when idle
//   ADDRESS     in   [7:0] device address, latched on accept
//   COMMAND     in   [7:0] command byte, latched on accept
//   IRDA_TXD    out  LED drive (envelope, or envelope gated by the 38 kHz carrier)
//   IR_ENVELOPE out  1 during marks, 0 during spaces, gap and idle
//   BUSY        out  frame in progress (leader through end of gap)
//   DONE        out  one-cycle pulse in the first idle cycle after the gap
//
// Build option: define CARRIER_EN to modulate IRDA_TXD with a square-wave carrier of
// half-period CARRIER_HALF; without it IRDA_TXD equals IR_ENVELOPE and no carrier logic exists.

module nec_ir_encoder #(
    parameter int unsigned LEAD_MARK    = 450000,
    parameter int unsigned LEAD_SPACE   = 225000,
    parameter int unsigned BIT_MARK     = 28125,
    parameter int unsigned ZERO_SPACE   = 28125,
    parameter int unsigned ONE_SPACE    = 84375,
    parameter int unsigned GAP_TIME     = 2000000,
    parameter int unsigned CARRIER_HALF = 658
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] ADDRESS,
    input  logic [7:0] COMMAND,
    output logic       IRDA_TXD,
    output logic       IR_ENVELOPE,
    output logic       BUSY,
    output logic       DONE
);

    // Counter wide enough for the longest segment, never narrower than 21 bits.
    localparam int unsigned MAX_A   = (LEAD_MARK  > LEAD_SPACE) ? LEAD_MARK  : LEAD_SPACE;
    localparam int unsigned MAX_B   = (BIT_MARK   > MAX_A)      ? BIT_MARK   : MAX_A;
    localparam int unsigned MAX_C   = (ZERO_SPACE > MAX_B)      ? ZERO_SPACE : MAX_B;
    localparam int unsigned MAX_D   = (ONE_SPACE  > MAX_C)      ? ONE_SPACE  : MAX_C;
    localparam int unsigned MAX_ALL = (GAP_TIME   > MAX_D)      ? GAP_TIME   : MAX_D;
    localparam int CW = ($clog2(MAX_ALL + 1) > 21) ? $clog2(MAX_ALL + 1) : 21;

    if (LEAD_MARK == 0 || LEAD_SPACE == 0 || BIT_MARK == 0 || ZERO_SPACE == 0 ||
        ONE_SPACE == 0 || GAP_TIME == 0 || CARRIER_HALF == 0) begin : g_param_check
        $error("nec_ir_encoder: every timing parameter must be at least 1");
    end

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LMARK  = 3'd1;
    localparam logic [2:0] S_LSPACE = 3'd2;
    localparam logic [2:0] S_BMARK  = 3'd3;
    localparam logic [2:0] S_BSPACE = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;
    localparam logic [2:0] S_GAP    = 3'd6;

    logic [2:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [5:0]    idx, idx_nxt;
    logic [31:0]   frame, frame_nxt;
    logic          env, env_nxt;
    logic          busy, busy_nxt;
    logic          done, done_nxt;
    logic          txd, txd_nxt;
    logic          last;

    // cnt holds the cycles remaining in the current segment including this one,
    // so a reload of N keeps the segment's output for exactly N cycles.
    assign last = (cnt == CW'(1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt - CW'(1);
        idx_nxt   = idx;
        frame_nxt = frame;
        env_nxt   = env;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt  = '0;
                env_nxt  = 1'b0;
                busy_nxt = 1'b0;
                if (START) begin
                    frame_nxt = {~COMMAND, COMMAND, ~ADDRESS, ADDRESS};
                    cnt_nxt   = CW'(LEAD_MARK);
                    idx_nxt   = '0;
                    env_nxt   = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = S_LMARK;
                end
            end
            S_LMARK: if (last) begin
                cnt_nxt   = CW'(LEAD_SPACE);
                env_nxt   = 1'b0;
                state_nxt = S_LSPACE;
            end
            S_LSPACE: if (last) begin
                cnt_nxt   = CW'(BIT_MARK);
                idx_nxt   = '0;
                env_nxt   = 1'b1;
                state_nxt = S_BMARK;
            end
            S_BMARK: if (last) begin
                // Pulse-distance coding: the bit value lives in the space length.
                cnt_nxt   = frame[idx[4:0]] ? CW'(ONE_SPACE) : CW'(ZERO_SPACE);
                env_nxt   = 1'b0;
                state_nxt = S_BSPACE;
            end
            S_BSPACE: if (last) begin
                cnt_nxt = CW'(BIT_MARK);
                env_nxt = 1'b1;
                if (idx == 6'd31) begin
                    state_nxt = S_STOP;
                end else begin
                    idx_nxt   = idx + 6'd1;
                    state_nxt = S_BMARK;
                end
            end
            S_STOP: if (last) begin
                cnt_nxt   = CW'(GAP_TIME);
                env_nxt   = 1'b0;
                state_nxt = S_GAP;
            end
            S_GAP: if (last) begin
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                env_nxt   = 1'b0;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef CARRIER_EN
    localparam int CCW = ($clog2(CARRIER_HALF + 1) < 1) ? 1 : $clog2(CARRIER_HALF + 1);

    logic           carrier, carrier_nxt;
    logic [CCW-1:0] car_cnt, car_cnt_nxt;

    // Every mark is preceded by a space or idle, so a rising envelope marks a
    // mark entry; the carrier restarts there with a full high half-period.
    always_comb begin
        carrier_nxt = 1'b0;
        car_cnt_nxt = '0;
        if (env_nxt && !env) begin
            carrier_nxt = 1'b1;
            car_cnt_nxt = CCW'(CARRIER_HALF);
        end else if (env_nxt) begin
            if (car_cnt == CCW'(1)) begin
                carrier_nxt = ~carrier;
                car_cnt_nxt = CCW'(CARRIER_HALF);
            end else begin
                carrier_nxt = carrier;
                car_cnt_nxt = car_cnt - CCW'(1);
            end
        end
        txd_nxt = env_nxt & carrier_nxt;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            carrier <= 1'b0;
            car_cnt <= '0;
        end else begin
            carrier <= carrier_nxt;
            car_cnt <= car_cnt_nxt;
        end
    end
`else
    always_comb txd_nxt = env_nxt;
`endif

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            frame <= '0;
            env   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            txd   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            frame <= frame_nxt;
            env   <= env_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            txd   <= txd_nxt;
        end
    end

    assign IR_ENVELOPE = env;
    assign IRDA_TXD    = txd;
    assign BUSY        = busy;
    assign DONE        = done;

endmodule

// File: tb/tb_nec_ir_encoder.sv
`timescale 1ns/1ps
// Bench for nec_ir_encoder with shortened timing parameters.
// A cycle-level reference model built from the frame's segment list scores every cycle,
// while table vectors and hand sequences decode whole frames and check corner cases.

module tb_nec_ir_encoder;

    localparam int unsigned LM = 20;
    localparam int unsigned LS = 10;
    localparam int unsigned BM = 2;
    localparam int unsigned ZS = 1;
    localparam int unsigned OS = 4;
    localparam int unsigned GT = 15;
    localparam int unsigned CH = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] cmd = 8'h00;
    logic       irda_txd, ir_envelope, busy, done;

    int checks = 0;
    int failures = 0;
    bit sb_en = 1'b0;

    nec_ir_encoder #(
        .LEAD_MARK(LM), .LEAD_SPACE(LS), .BIT_MARK(BM), .ZERO_SPACE(ZS),
        .ONE_SPACE(OS), .GAP_TIME(GT), .CARRIER_HALF(CH)
    ) dut (
        .CLOCK_50(clk), .RESET(rst), .START(start), .ADDRESS(addr), .COMMAND(cmd),
        .IRDA_TXD(irda_txd), .IR_ENVELOPE(ir_envelope), .BUSY(busy), .DONE(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Envelope length of a frame: leader, 32 (mark + space), stop mark.
    function automatic int flen(input logic [31:0] w);
        int s = LM + LS + BM;
        for (int i = 0; i < 32; i++) s += BM + (w[i] ? OS : ZS);
        return s;
    endfunction

    // Envelope and LED drive at cycle t (1 = first cycle after accept) of a frame.
    function automatic void ref_at(input logic [31:0] w, input int t, output bit env, output bit txd);
        int rem = t - 1;
        env = 1'b0;
        txd = 1'b0;
        for (int s = 0; s < 67; s++) begin
            int len;
            bit lvl;
            lvl = (s % 2 == 0);
            if (s == 0)       len = LM;
            else if (s == 1)  len = LS;
            else if (lvl)     len = BM;
            else              len = w[(s - 3) / 2] ? OS : ZS;
            if (rem < len) begin
                env = lvl;
`ifdef CARRIER_EN
                txd = lvl && ((rem / CH) % 2 == 0);
`else
                txd = lvl;
`endif
                return;
            end
            rem -= len;
        end
    endfunction

    bit          m_active = 1'b0;
    int          m_t = 0;
    logic [31:0] m_word = '0;

    // m_t runs 1..flen+GT+1; the last value is the DONE cycle, in which a new START is taken.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_t      <= 0;
        end else if (m_active && m_t != flen(m_word) + GT + 1) begin
            m_t <= m_t + 1;
        end else if (start) begin
            m_active <= 1'b1;
            m_t      <= 1;
            m_word   <= {~cmd, cmd, ~addr, addr};
        end else begin
            m_active <= 1'b0;
            m_t      <= 0;
        end
    end

    always @(negedge clk) begin : scoreboard
        bit ee, et, eb, ed;
        if (sb_en) begin
            ee = 1'b0; et = 1'b0; eb = 1'b0; ed = 1'b0;
            if (m_active) begin
                if (m_t == flen(m_word) + GT + 1) begin
                    ed = 1'b1;
                end else begin
                    eb = 1'b1;
                    if (m_t <= flen(m_word)) ref_at(m_word, m_t, ee, et);
                end
            end
            check("sb_envelope", ir_envelope, ee);
            check("sb_txd", irda_txd, et);
            check("sb_busy", busy, eb);
            check("sb_done", done, ed);
        end
    end

    // ---------------- frame capture and decode ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] c, input bit hold, input int poke_at,
                             output logic [31:0] word, output int lead, output int span,
                             output int done_at, output int sp0, output int sp1);
        bit q[$];
        int rl[$];
        int len;
        bit lvl;
        word = '0; lead = 0; span = 0; done_at = -1; sp0 = 0; sp1 = 0;
        start = 1'b1; addr = a; cmd = c;
        for (int n = 1; n <= 1000 && done_at < 0; n++) begin
            @(negedge clk);
            q.push_back(ir_envelope);
            if (done) done_at = n;
            #1;
            if (n == 1 && !hold) start = 1'b0;
            if (poke_at > 0 && n == poke_at) begin
                start = 1'b1; addr = ~a; cmd = c ^ 8'h57;
            end
            if (poke_at > 0 && n == poke_at + 1) start = 1'b0;
        end
        lvl = 1'b1;
        len = 0;
        foreach (q[i]) begin
            if (q[i] == lvl) len++;
            else begin
                rl.push_back(len);
                lvl = q[i];
                len = 1;
            end
            if (q[i]) span = i + 1;
        end
        rl.push_back(len);
        lead = rl[0];
        for (int i = 0; i < 32; i++)
            if (3 + 2 * i < rl.size()) word[i] = (rl[3 + 2 * i] == OS);
        if (rl.size() > 3) sp0 = rl[3];
        if (rl.size() > 5) sp1 = rl[5];
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  c;
        logic [31:0] word;
        int          lead;
        int          span;
        int          done_at;
        int          sp0;
        int          sp1;
    } vec_t;

    vec_t tbl[4];

    // Watchdog: should never fire, every wait below is bounded.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int lead, span, dat, sp0, sp1, ndone;

        // Frame = {~cmd, cmd, ~addr, addr}; spans: 20+10+64+16*1+16*4+2 = 176, DONE at 176+15+1.
        tbl[0] = '{8'h00, 8'h45, 32'hBA45FF00, 20, 176, 192, 1, 1};
        tbl[1] = '{8'h01, 8'h00, 32'hFF00FE01, 20, 176, 192, 4, 1};
        tbl[2] = '{8'h5A, 8'h3C, 32'hC33CA55A, 20, 176, 192, 1, 4};
        tbl[3] = '{8'hFF, 8'hFF, 32'h00FF00FF, 20, 176, 192, 4, 4};

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("reset_envelope", ir_envelope, 0);
        check("reset_txd", irda_txd, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        step();
        step();
        rst = 1'b0;
        step();
        sb_en = 1'b1;

        // Reset mid-frame in the leader space: outputs clear without a clock edge, no DONE.
        start = 1'b1; addr = 8'h33; cmd = 8'h44;
        step();
        start = 1'b0;
        repeat (23) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_envelope", ir_envelope, 0);
        check("abort_done", done, 0);
        step();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        #1;

        // Table vectors (the first also shows a full leader after the abort).
        for (int i = 0; i < 4; i++) begin
            run_frame(tbl[i].a, tbl[i].c, 1'b0, 0, w, lead, span, dat, sp0, sp1);
            check("tbl_word", w, tbl[i].word);
            check("tbl_lead", lead, tbl[i].lead);
            check("tbl_span", span, tbl[i].span);
            check("tbl_done_at", dat, tbl[i].done_at);
            check("tbl_space0", sp0, tbl[i].sp0);
            check("tbl_space1", sp1, tbl[i].sp1);
            step();
            step();
        end

        // START while busy is ignored; inputs changed after accept do not leak in.
        run_frame(8'h10, 8'h12, 1'b0, 25, w, lead, span, dat, sp0, sp1);
        check("busy_word", w, 32'hED12EF10);
        check("busy_done_at", dat, 192);
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("busy_single_done", ndone, 0);
        #1;

        // Back-to-back: second leader starts in the cycle right after DONE.
        run_frame(8'h21, 8'h43, 1'b1, 0, w, lead, span, dat, sp0, sp1);
        check("b2b_first_word", w, 32'hBC43DE21);
        check("b2b_first_done", dat, 192);
        run_frame(8'h65, 8'h87, 1'b0, 0, w, lead, span, dat, sp0, sp1);
        check("b2b_second_word", w, 32'h78879A65);
        check("b2b_second_lead", lead, 20);
        check("b2b_second_done", dat, 192);
        step();

        // Randomised traffic against the model: sparse and held STARTs, changing data, rare resets.
        for (int i = 0; i < 4000; i++) begin
            if (i >= 1500 && i < 2000) start = 1'b1;
            else start = ($urandom_range(0, 29) == 0);
            addr = 8'($urandom);
            cmd  = 8'($urandom);
            rst  = ($urandom_range(0, 1499) == 0);
            step();
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
